// File: rtl/code_sequencer_pkg.sv
// Shared lock-subsystem definitions: sequencer state encodings, colour symbols
// and the default unlock code.
package code_sequencer_pkg;

  typedef enum logic [2:0] {
    S_Idle  = 3'd0,
    S_Start = 3'd1,
    S_Gap   = 3'd2,
    S_Sym   = 3'd3,
    S_Done  = 3'd4
  } state_t;

  localparam logic [1:0] SYM_PAUSE = 2'b00;
  localparam logic [1:0] SYM_R     = 2'b01;
  localparam logic [1:0] SYM_G     = 2'b10;
  localparam logic [1:0] SYM_B     = 2'b11;

  // R,B,G,R sent LSB pair first
  localparam logic [7:0] CODE_UNLOCK = 8'h6D;

  // Returns {r, g, b} line levels for one symbol.
  function automatic logic [2:0] sym_lines(input logic [1:0] sym);
    logic [2:0] lines;
    lines = '0;
    case (sym)
      SYM_R:   lines = 3'b100;
      SYM_G:   lines = 3'b010;
      SYM_B:   lines = 3'b001;
      default: lines = '0;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/code_sequencer_gap.sv
// Gap timer for the code sequencer: load clears the count, otherwise it counts
// up every cycle; tc flags the terminal count LAST.
module code_seq_gap_timer #(
  parameter int unsigned     GAPW = 4,
  parameter logic [GAPW-1:0] LAST = '0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic load,
  output logic tc
);

  logic [GAPW-1:0] count;

  always_ff @(posedge Clk) begin
    if (Rst || load) begin
      count <= '0;
    end else begin
      count <= count + GAPW'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/code_sequencer.sv
// Colour-code transmitter: on Go, sends Start then four R/G/B/pause symbols
// separated by GAP idle cycles, then a one-cycle Done.
module code_sequencer
  import code_sequencer_pkg::*;
#(
  parameter int unsigned GAP  = 2,
  parameter int unsigned GAPW = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Go,
  input  logic [7:0] Code,
  output logic       Start,
  output logic       R,
  output logic       G,
  output logic       B,
  output logic       Busy,
  output logic       Done
);

  localparam logic [GAPW-1:0] GAP_LAST = GAPW'((GAP > 0) ? GAP - 1 : 0);

  state_t     state, state_n;
  logic [7:0] code_reg, code_reg_n;
  logic [1:0] idx, idx_n;
  logic       gap_load, gap_tc;
  logic       start_n, r_n, g_n, b_n, busy_n, done_n;

  code_seq_gap_timer #(
    .GAPW(GAPW),
    .LAST(GAP_LAST)
  ) u_gap (
    .Clk (Clk),
    .Rst (Rst),
    .load(gap_load),
    .tc  (gap_tc)
  );

  always_comb begin
    state_n    = state;
    code_reg_n = code_reg;
    idx_n      = idx;
    gap_load   = 1'b0;
    case (state)
      S_Idle: begin
        if (Go) begin
          code_reg_n = Code;
          idx_n      = '0;
          state_n    = S_Start;
        end
      end
      S_Start: begin
        if (GAP > 0) begin
          gap_load = 1'b1;
          state_n  = S_Gap;
        end else begin
          state_n = S_Sym;
        end
      end
      S_Gap: begin
        if (gap_tc) state_n = S_Sym;
      end
      S_Sym: begin
        if (idx == 2'd3) begin
          state_n = S_Done;
        end else begin
          idx_n = idx + 2'd1;
          if (GAP > 0) begin
            gap_load = 1'b1;
            state_n  = S_Gap;
          end else begin
            state_n = S_Sym;
          end
        end
      end
      S_Done: begin
        if (Go) begin
          code_reg_n = Code;
          idx_n      = '0;
          state_n    = S_Start;
        end else begin
          state_n = S_Idle;
        end
      end
      default: state_n = S_Idle;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    start_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    {r_n, g_n, b_n} = '0;
    case (state_n)
      S_Start: begin
        start_n = 1'b1;
        busy_n  = 1'b1;
      end
      S_Gap: busy_n = 1'b1;
      S_Sym: begin
        busy_n = 1'b1;
        {r_n, g_n, b_n} = sym_lines(code_reg_n[{idx_n, 1'b0} +: 2]);
      end
      S_Done: done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_Idle;
      code_reg <= '0;
      idx      <= '0;
      Start    <= 1'b0;
      R        <= 1'b0;
      G        <= 1'b0;
      B        <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_n;
      code_reg <= code_reg_n;
      idx      <= idx_n;
      Start    <= start_n;
      R        <= r_n;
      G        <= g_n;
      B        <= b_n;
      Busy     <= busy_n;
      Done     <= done_n;
    end
  end

endmodule

// File: tb/tb_code_sequencer.sv
// Randomised bench for code_sequencer at GAP=2 and GAP=0, checked against a
// timeline model computed from each sequence's start cycle.
module tb_code_sequencer;
  import code_sequencer_pkg::*;

  localparam int unsigned GAP_A = 2;
  localparam int unsigned GAP_B = 0;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Go  = 1'b0;
  logic [7:0] Code = '0;

  logic start_a, r_a, g_a, b_a, busy_a, done_a;
  logic start_b, r_b, g_b, b_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit         m_active [2];
  int         m_start  [2];
  logic [7:0] m_code   [2];
  int         m_gap    [2];

  int first_start [2];
  int first_done  [2];

  code_sequencer #(.GAP(GAP_A), .GAPW(4)) dut_a (
    .Clk(Clk), .Rst(Rst), .Go(Go), .Code(Code),
    .Start(start_a), .R(r_a), .G(g_a), .B(b_a), .Busy(busy_a), .Done(done_a)
  );

  code_sequencer #(.GAP(GAP_B), .GAPW(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .Go(Go), .Code(Code),
    .Start(start_b), .R(r_b), .G(g_b), .B(b_b), .Busy(busy_b), .Done(done_b)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected {Start,R,G,B,Busy,Done} at offset d from the Start cycle.
  function automatic logic [5:0] expect_out(input int gap, input bit active,
                                            input int d, input logic [7:0] code);
    logic [5:0] res;
    logic [7:0] sh;
    int last, k;
    res  = '0;
    last = 5 + 4 * gap;
    if (active) begin
      if (d == 0) res[5] = 1'b1;
      if (d < last) res[1] = 1'b1;
      if (d == last) res[0] = 1'b1;
      if (d >= 1 + gap && ((d - 1 - gap) % (gap + 1)) == 0) begin
        k = (d - 1 - gap) / (gap + 1);
        if (k < 4) begin
          sh = code >> (2 * k);
          case (sh[1:0])
            2'd1: res[4] = 1'b1;
            2'd2: res[3] = 1'b1;
            2'd3: res[2] = 1'b1;
            default: ;
          endcase
        end
      end
    end
    return res;
  endfunction

  initial begin
    m_gap[0] = GAP_A;
    m_gap[1] = GAP_B;
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_start[i]  = 0;
      m_code[i]   = '0;
    end
  end

  // Sequence-level model: a sequence may begin when idle or in its Done cycle.
  always @(posedge Clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int last;
      bit in_done;
      last    = 5 + 4 * m_gap[i];
      in_done = m_active[i] && ((cyc - 1 - m_start[i]) == last);
      if (Rst) begin
        m_active[i] = 1'b0;
      end else if ((!m_active[i] || in_done) && Go) begin
        m_active[i] = 1'b1;
        m_start[i]  = cyc;
        m_code[i]   = Code;
      end else if (in_done) begin
        m_active[i] = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge Clk);
      check("out_a", {26'd0, start_a, r_a, g_a, b_a, busy_a, done_a},
            {26'd0, expect_out(m_gap[0], m_active[0], cyc - m_start[0], m_code[0])});
      check("out_b", {26'd0, start_b, r_b, g_b, b_b, busy_b, done_b},
            {26'd0, expect_out(m_gap[1], m_active[1], cyc - m_start[1], m_code[1])});
      check("excl_a", 32'($countones({start_a, r_a, g_a, b_a}) <= 1), 32'd1);
      check("excl_b", 32'($countones({start_b, r_b, g_b, b_b}) <= 1), 32'd1);
      if (start_a && first_start[0] < 0) first_start[0] = cyc;
      if (done_a  && first_done[0]  < 0) first_done[0]  = cyc;
      if (start_b && first_start[1] < 0) first_start[1] = cyc;
      if (done_b  && first_done[1]  < 0) first_done[1]  = cyc;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      first_start[i] = -1;
      first_done[i]  = -1;
    end

    // Reset, then idle
    Rst = 1'b1;
    step(2);
    Rst = 1'b0;
    step(10);

    // Unlock code, single Go pulse
    Code = CODE_UNLOCK;
    Go   = 1'b1;
    step(1);
    Go   = 1'b0;
    Code = 8'hFF;
    step(20);
    check("span_a", 32'(first_done[0] - first_start[0]), 32'd13);
    check("span_b", 32'(first_done[1] - first_start[1]), 32'd5);

    // All-pause code
    Code = 8'h00;
    Go   = 1'b1;
    step(1);
    Go   = 1'b0;
    step(18);

    // Go held high with Code changing every cycle
    Go = 1'b1;
    for (int j = 0; j < 45; j++) begin
      Code = 8'($urandom);
      step(1);
    end
    Go = 1'b0;
    step(16);

    // Reset on the symbol-2 cycle of the GAP=2 unit, then a fresh sequence
    Code = CODE_UNLOCK;
    Go   = 1'b1;
    step(1);
    Go   = 1'b0;
    step(9);
    Rst = 1'b1;
    step(1);
    Rst = 1'b0;
    check("rst_mid_a", {26'd0, start_a, r_a, g_a, b_a, busy_a, done_a}, 32'd0);
    step(3);
    Code = 8'($urandom);
    Go   = 1'b1;
    step(1);
    Go   = 1'b0;
    step(16);

    // Random traffic with occasional resets
    for (int j = 0; j < 400; j++) begin
      Go   = ($urandom_range(0, 3) == 0);
      Code = 8'($urandom);
      Rst  = ($urandom_range(0, 99) == 0);
      step(1);
    end
    Rst = 1'b0;
    Go  = 1'b0;
    step(16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_sequencer.md
Name: code_sequencer

Overview:
- Transmit end of the colour-code lock interface. On a Go request it drives the Start, R, G, B lines with a 4-symbol code sequence, so a code detector downstream can be exercised or unlocked.
- Symbols are one-cycle pulses separated by a programmable number of all-zero gap cycles.
- Sits beside the detector in the lock subsystem; also used as the stimulus engine in system benches.

Parameters:
- GAP, 2, number of all-zero idle cycles after Start and between consecutive symbols (0 = back-to-back; legal 0..15).
- GAPW, 4, width of the gap counter; must satisfy 2^GAPW > GAP.

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Go  input  1  request to send one sequence; sampled each rising edge.
- Code  input  8  four 2-bit symbols. Code[1:0] is sent first, Code[7:6] last. Encoding: 01=R, 10=G, 11=B, 00=pause (all lines low for that slot).
- Start  output  1  one-cycle start pulse.
- R  output  1  red pulse.
- G  output  1  green pulse.
- B  output  1  blue pulse.
- Busy  output  1  high from the Start cycle through the last symbol cycle.
- Done  output  1  one-cycle pulse on the cycle after the last symbol.

Behaviour:
- Reset, clock: reset is Rst, synchronous, active-high; clock is Clk.
- Outputs at reset: all outputs are registered and all are 0 the cycle after Rst is sampled high. State returns to S_Idle. Counters are cleared.
- Reset mid-sequence: sequence aborted, no Done pulse.
- States:
  - S_Idle: Go=1 latches Code into CodeReg -> S_Start. Go=0 -> stay.
  - S_Start: Start=1, Busy=1. If GAP>0 -> S_Gap with gap count 0, else -> S_Sym.
  - S_Gap: all lines 0, Busy=1. Stay until gap count = GAP-1, then -> S_Sym.
  - S_Sym: exactly one of R/G/B high per CodeReg[2*idx+1:2*idx] (or none for 00), Busy=1.
    - idx<3: idx++, then -> S_Gap (GAP>0) or S_Sym (GAP=0).
    - idx=3: -> S_Done.
  - S_Done: Done=1, Busy=0, lines 0. Go=1 relatches Code -> S_Start (back-to-back sequences). Otherwise -> S_Idle.
- Timing: with Go sampled high at edge t:
  - Start at cycle t+1.
  - Symbol k at cycle t+2+GAP+k*(GAP+1).
  - Done at t+6+4*GAP.
  - GAP=2: Start t+1, symbols t+4/t+7/t+10/t+13, Done t+14.
- Go handling: ignored in S_Start, S_Gap and S_Sym; it is not queued. Code changes after latching have no effect on a sequence in flight.
- Exclusivity: Start, R, G and B are never high together. At most one of them is high in any cycle.
- Illegal state encodings: recover to S_Idle with all outputs 0.
- Counters:
  - idx is 2 bits and never wraps within a sequence; it is cleared on entry to S_Start.
  - Gap counter is GAPW bits, saturation-free, and cleared on each S_Gap entry.

Decomposition:
- Shared lock package holds:
  - State encodings S_Idle..S_Done (3 bits).
  - Symbol constants SYM_PAUSE=2'b00, SYM_R=2'b01, SYM_G=2'b10, SYM_B=2'b11.
  - The default unlock code CODE_UNLOCK=8'h6D, which encodes R,B,G,R.
- One sub-module is natural: code_seq_gap_timer. It is a GAPW-bit load/count/terminal-count timer.
- Symbol decode and the FSM stay in the top module.

Test Plan:
- Rst high 2 cycles, then Go=0 for 10 cycles -> Start/R/G/B/Busy/Done all 0 throughout.
- GAP=2, Code=8'h6D, Go pulse at t:
  - Start@t+1, R@t+4, B@t+7, G@t+10, R@t+13, Done@t+14.
  - Busy high t+1..t+13.
  - Connected detector asserts its unlock output.
- GAP=0, Code=8'h6D: Start@t+1, then R,B,G,R on t+2..t+5, Done@t+6; no gap cycles.
- Code=8'h00 -> Start pulse, then 4 pause slots with R=G=B=0, Done@t+6+4*GAP.
- Go held high continuously, with Code changed mid-sequence:
  - First sequence uses the originally latched code.
  - Go at Done starts the next Start on the following cycle.
  - No extra sequences start while Busy.
- Rst asserted on the cycle of symbol 2 -> next cycle all outputs 0, no Done; a fresh Go afterwards produces a full correct sequence.
